// File: rtl/issue_exec_stage_alu_pipe.sv
// ALU issue/execute stage: computes result and flags for one reservation-station
// entry per cycle and buffers them in a DEPTH-entry output FIFO.
// Ports: clk_i/reset_i; reservationStation* operands, command, tag and readyRS_i in,
// stallRS_o out; flush_i; canGo_i in; valid_o and execute* head entry out;
// occupancy_o out.
module issue_exec_stage_alu_pipe #(
  parameter int DATA_W     = 64,
  parameter int CMD_W      = 10,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int DEPTH      = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [DATA_W-1:0]           reservationStationVal1_i,
  input  logic [DATA_W-1:0]           reservationStationVal2_i,
  input  logic [CMD_W-1:0]            reservationStationCommands_i,
  input  logic [ROBsizeLog-1:0]       reservationStationTag_i,
  input  logic                        readyRS_i,
  output logic                        stallRS_o,
  input  logic                        flush_i,
  input  logic                        canGo_i,
  output logic                        valid_o,
  output logic [DATA_W-1:0]           executeVal_o,
  output logic [CMD_W-1:0]            executeCommands_o,
  output logic [ROBsizeLog-1:0]       executeTag_o,
  output logic [3:0]                  executeFlags_o,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  logic [DATA_W-1:0] a, b;
  logic [2:0]        op;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic              ovf;
  logic [DATA_W-1:0] res;
  logic              cy;
  logic              vf;
  logic              kill;
  logic [3:0]        flg;

  assign a  = reservationStationVal1_i;
  assign b  = reservationStationVal2_i;
  assign op = reservationStationCommands_i[4:2];

  // Subtract reuses the adder as A + ~B + 1 so carry_out means "no borrow".
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff}
               + {{DATA_W{1'b0}}, (op == OP_SUB)};
  assign ovf   = (a[DATA_W-1] == b_eff[DATA_W-1])
               && (sum[DATA_W-1] != a[DATA_W-1]);

  always_comb begin
    res  = '0;
    cy   = 1'b0;
    vf   = 1'b0;
    kill = 1'b0;
    case (op)
      OP_PASS: res = b;
      OP_ADD, OP_SUB: begin
        res = sum[DATA_W-1:0];
        cy  = sum[DATA_W];
        vf  = ovf;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      default: kill = 1'b1;
    endcase
  end

  // Undefined ops report all-zero flags, including zero.
  assign flg = kill ? 4'b0000
                    : {cy, vf, (res == '0), res[DATA_W-1]};

  logic [DATA_W-1:0]     mem_val [DEPTH];
  logic [CMD_W-1:0]      mem_cmd [DEPTH];
  logic [ROBsizeLog-1:0] mem_tag [DEPTH];
  logic [3:0]            mem_flg [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  // stallRS_o depends only on the registered count, never on canGo_i.
  assign stallRS_o   = (count == CNT_W'(DEPTH));
  assign valid_o     = (count != '0);
  assign occupancy_o = count;

  assign push = readyRS_i & ~stallRS_o & ~flush_i;
  assign pop  = valid_o & canGo_i & ~flush_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_val[i] <= '0;
        mem_cmd[i] <= '0;
        mem_tag[i] <= '0;
        mem_flg[i] <= '0;
      end
    end else if (push) begin
      mem_val[wr_ptr] <= res;
      mem_cmd[wr_ptr] <= reservationStationCommands_i;
      mem_tag[wr_ptr] <= reservationStationTag_i;
      mem_flg[wr_ptr] <= flg;
    end
  end

  assign executeVal_o      = mem_val[rd_ptr];
  assign executeCommands_o = mem_cmd[rd_ptr];
  assign executeTag_o      = mem_tag[rd_ptr];
  assign executeFlags_o    = mem_flg[rd_ptr];

endmodule

// File: tb/tb_issue_exec_stage_alu_pipe.sv
// Directed bench for issue_exec_stage_alu_pipe (DATA_W=64, DEPTH=2).
// ALU vector table plus back-pressure, streaming, flush and async reset sequences.
module tb_issue_exec_stage_alu_pipe;

  localparam int DW = 64;
  localparam int CW = 10;
  localparam int TW = 6;
  localparam int OW = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] va, vb;
  logic [CW-1:0] cmd;
  logic [TW-1:0] tag;
  logic          ready;
  logic          stall;
  logic          flush;
  logic          can_go;
  logic          valid;
  logic [DW-1:0] x_val;
  logic [CW-1:0] x_cmd;
  logic [TW-1:0] x_tag;
  logic [3:0]    x_flg;
  logic [OW-1:0] occ;

  int n_tests = 0;
  int n_fail  = 0;

  issue_exec_stage_alu_pipe #(
    .DATA_W(DW), .CMD_W(CW), .ROBsize(32), .DEPTH(2)
  ) dut (
    .clk_i                        (clk),
    .reset_i                      (rst),
    .reservationStationVal1_i     (va),
    .reservationStationVal2_i     (vb),
    .reservationStationCommands_i (cmd),
    .reservationStationTag_i      (tag),
    .readyRS_i                    (ready),
    .stallRS_o                    (stall),
    .flush_i                      (flush),
    .canGo_i                      (can_go),
    .valid_o                      (valid),
    .executeVal_o                 (x_val),
    .executeCommands_o            (x_cmd),
    .executeTag_o                 (x_tag),
    .executeFlags_o               (x_flg),
    .occupancy_o                  (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
    logic [TW-1:0] tg;
    logic [DW-1:0] res;
    logic [3:0]    flg;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] mk_cmd(input logic [2:0] op);
    return {5'b00000, op, 2'b01};
  endfunction

  task automatic drive(input logic [TW-1:0] t,
                       input logic [DW-1:0] a,
                       input logic [DW-1:0] b,
                       input logic [2:0] op);
    ready = 1'b1;
    tag   = t;
    va    = a;
    vb    = b;
    cmd   = mk_cmd(op);
  endtask

  initial begin
    vecs[0]  = '{64'd15, 64'd3, 3'b010, 6'd3, 64'd18, 4'b0000};
    vecs[1]  = '{64'd3, 64'd3, 3'b011, 6'd4, 64'd0, 4'b1010};
    vecs[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 6'd5,
                 64'h8000_0000_0000_0000, 4'b0101};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 6'd6,
                 64'd0, 4'b1010};
    vecs[4]  = '{64'hF0F0, 64'hFF00, 3'b100, 6'd7, 64'hF000, 4'b0000};
    vecs[5]  = '{64'hF0, 64'h0F, 3'b101, 6'd8, 64'hFF, 4'b0000};
    vecs[6]  = '{64'd5, 64'd5, 3'b110, 6'd9, 64'd0, 4'b0010};
    vecs[7]  = '{64'd1, 64'h8000_0000_0000_0000, 3'b000, 6'd10,
                 64'h8000_0000_0000_0000, 4'b0001};
    vecs[8]  = '{64'd1, 64'd2, 3'b001, 6'd11, 64'd0, 4'b0000};
    vecs[9]  = '{64'd1, 64'd2, 3'b111, 6'd12, 64'd0, 4'b0000};
    vecs[10] = '{64'd2, 64'd3, 3'b011, 6'd13,
                 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001};
    vecs[11] = '{64'h8000_0000_0000_0000, 64'd1, 3'b011, 6'd14,
                 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100};

    rst    = 1'b1;
    ready  = 1'b0;
    flush  = 1'b0;
    can_go = 1'b0;
    va     = '0;
    vb     = '0;
    cmd    = '0;
    tag    = '0;
    #1;
    chk("reset_valid", DW'(valid), 0);
    chk("reset_stall", DW'(stall), 0);
    chk("reset_occ", DW'(occ), 0);
    chk("reset_val", x_val, 0);
    chk("reset_tag", DW'(x_tag), 0);
    chk("reset_flg", DW'(x_flg), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].tg, vecs[i].a, vecs[i].b, vecs[i].op);
      can_go = 1'b0;
      tick();
      ready = 1'b0;
      chk($sformatf("v%0d_valid", i), DW'(valid), 1);
      chk($sformatf("v%0d_res", i), x_val, vecs[i].res);
      chk($sformatf("v%0d_flg", i), DW'(x_flg), DW'(vecs[i].flg));
      chk($sformatf("v%0d_tag", i), DW'(x_tag), DW'(vecs[i].tg));
      chk($sformatf("v%0d_cmd", i), DW'(x_cmd), DW'(mk_cmd(vecs[i].op)));
      chk($sformatf("v%0d_occ", i), DW'(occ), 1);
      can_go = 1'b1;
      tick();
      can_go = 1'b0;
      chk($sformatf("v%0d_popped", i), DW'(valid), 0);
    end

    // Back-pressure: RS holds tag 3 until it is accepted.
    can_go = 1'b0;
    drive(6'd1, 64'd1, 64'd0, 3'b010);
    tick();
    chk("bp_stall_after_1", DW'(stall), 0);
    drive(6'd2, 64'd2, 64'd0, 3'b010);
    tick();
    chk("bp_stall_full", DW'(stall), 1);
    chk("bp_occ_full", DW'(occ), 2);
    drive(6'd3, 64'd3, 64'd0, 3'b010);
    tick();
    chk("bp_held_occ", DW'(occ), 2);
    chk("bp_held_head", DW'(x_tag), 1);
    chk("bp_held_val", x_val, 1);
    can_go = 1'b1;
    tick();
    chk("bp_pop1_occ", DW'(occ), 1);
    chk("bp_pop1_stall", DW'(stall), 0);
    chk("bp_pop1_head", DW'(x_tag), 2);
    tick();
    ready = 1'b0;
    chk("bp_pop2_occ", DW'(occ), 1);
    chk("bp_pop2_head", DW'(x_tag), 3);
    chk("bp_pop2_val", x_val, 3);
    tick();
    can_go = 1'b0;
    chk("bp_drained", DW'(valid), 0);

    // Streaming: one result per cycle, occupancy steady at 1.
    can_go = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(TW'(i + 1), DW'(i + 100), 64'd0, 3'b010);
      tick();
      chk($sformatf("st%0d_tag", i), DW'(x_tag), DW'(i + 1));
      chk($sformatf("st%0d_val", i), x_val, DW'(i + 100));
      chk($sformatf("st%0d_occ", i), DW'(occ), 1);
      chk($sformatf("st%0d_stall", i), DW'(stall), 0);
    end
    ready = 1'b0;
    tick();
    can_go = 1'b0;
    chk("st_drained", DW'(valid), 0);

    // Flush when full with an entry presented.
    drive(6'd20, 64'd0, 64'd0, 3'b010);
    tick();
    drive(6'd21, 64'd0, 64'd0, 3'b010);
    tick();
    chk("fl_full", DW'(stall), 1);
    drive(6'd22, 64'd0, 64'd0, 3'b010);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ready = 1'b0;
    chk("fl_valid", DW'(valid), 0);
    chk("fl_occ", DW'(occ), 0);
    chk("fl_stall", DW'(stall), 0);
    // Flush with one stored entry and a push that would otherwise land.
    drive(6'd23, 64'd0, 64'd0, 3'b010);
    tick();
    drive(6'd24, 64'd0, 64'd0, 3'b010);
    flush = 1'b1;
    can_go = 1'b1;
    tick();
    flush = 1'b0;
    can_go = 1'b0;
    ready = 1'b0;
    chk("fl2_occ", DW'(occ), 0);
    drive(6'd25, 64'd7, 64'd0, 3'b010);
    tick();
    ready = 1'b0;
    chk("fl_resume_tag", DW'(x_tag), 25);
    chk("fl_resume_occ", DW'(occ), 1);
    can_go = 1'b1;
    tick();
    can_go = 1'b0;

    // Asynchronous reset between edges while full.
    drive(6'd5, 64'd55, 64'd0, 3'b010);
    tick();
    drive(6'd6, 64'd66, 64'd0, 3'b010);
    tick();
    ready = 1'b0;
    chk("ar_full", DW'(occ), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", DW'(valid), 0);
    chk("ar_occ", DW'(occ), 0);
    chk("ar_stall", DW'(stall), 0);
    chk("ar_val", x_val, 0);
    chk("ar_tag", DW'(x_tag), 0);
    #1;
    rst = 1'b0;
    tick();
    drive(6'd7, 64'd40, 64'd2, 3'b010);
    tick();
    ready = 1'b0;
    chk("ar_resume_tag", DW'(x_tag), 7);
    chk("ar_resume_val", x_val, 42);
    chk("ar_resume_occ", DW'(occ), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
